// File: rtl/lfsr_encrypt_engine.sv
// rtl/lfsr_encrypt_engine.sv - hardwired LFSR stream cipher over data memory
//
// Purpose: reads a 41-byte plaintext plus three config bytes (pre_len, taps,
// lfsr_init) from data memory, then writes 64 ciphertext bytes, each being the
// space-padded message byte XOR the current LFSR state. Runs once every time
// start deasserts and raises halt when the output region is complete.
//
// Ports:
//   clk          rising-edge clock
//   start        asynchronous active-high reset; the engine runs while low
//   mem_addr     data-memory address (read or write)
//   mem_rd_data  data-memory read data, valid the cycle after mem_addr
//   mem_wr_en    data-memory write strobe, one cycle per ciphertext byte
//   mem_wr_data  ciphertext byte
//   halt         high once all ciphertext bytes are written

module lfsr_encrypt_engine #(
  parameter int          AW       = 8,
  parameter int          MSG_LEN  = 41,
  parameter int          CFG_BASE = 41,
  parameter int          OUT_BASE = 64,
  parameter int          OUT_LEN  = 64,
  parameter logic [7:0]  PAD      = 8'h20
) (
  input  logic          clk,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          halt
);

  typedef enum logic [2:0] {
    S_CFG0,
    S_CFG1,
    S_CFG2,
    S_CFG3,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] CFG_ADDR  = AW'(CFG_BASE);
  localparam logic [AW-1:0] OUT_ADDR  = AW'(OUT_BASE);
  localparam logic [8:0]    MSG_LEN9  = 9'(MSG_LEN);
  localparam logic [6:0]    LAST_BYTE = 7'(OUT_LEN - 1);

  state_t     state_q, state_d;
  logic [6:0] i_q, i_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] taps_q, taps_d;
  logic [7:0] lfsr_q, lfsr_d;

  logic [8:0]    i9;
  logic [8:0]    pre9;
  logic          in_msg;
  logic [7:0]    msg_off;
  logic [7:0]    pt;

  // 9-bit compare so that pre_len + MSG_LEN never wraps for large pre_len.
  assign i9      = {2'b00, i_q};
  assign pre9    = {1'b0, pre_q};
  assign in_msg  = (i9 >= pre9) && (i9 < (pre9 + MSG_LEN9));
  assign msg_off = {1'b0, i_q} - pre_q;
  assign pt      = in_msg ? mem_rd_data : PAD;

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state_q <= S_CFG0;
      i_q     <= '0;
      pre_q   <= '0;
      taps_q  <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Memory reads are one cycle late, so each config byte is captured on the
  // edge after the state that presented its address.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    pre_d       = pre_q;
    taps_d      = taps_q;
    lfsr_d      = lfsr_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    halt        = 1'b0;

    unique case (state_q)
      S_CFG0: begin
        mem_addr = CFG_ADDR;
        state_d  = S_CFG1;
      end
      S_CFG1: begin
        mem_addr = CFG_ADDR + AW'(1);
        pre_d    = mem_rd_data;
        state_d  = S_CFG2;
      end
      S_CFG2: begin
        mem_addr = CFG_ADDR + AW'(2);
        taps_d   = mem_rd_data;
        state_d  = S_CFG3;
      end
      S_CFG3: begin
        lfsr_d  = mem_rd_data;
        state_d = S_RD;
      end
      S_RD: begin
        // Padding bytes need no read; park the address at 0 (read-only area).
        mem_addr = in_msg ? AW'(msg_off) : '0;
        state_d  = S_WR;
      end
      S_WR: begin
        mem_addr    = OUT_ADDR + AW'(i_q);
        mem_wr_en   = 1'b1;
        mem_wr_data = pt ^ lfsr_q;
        lfsr_d      = {lfsr_q[6:0], ^(lfsr_q & taps_q)};
        i_d         = i_q + 7'd1;
        state_d     = (i_q == LAST_BYTE) ? S_DONE : S_RD;
      end
      S_DONE: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// tb/tb_lfsr_encrypt_engine.sv - scoreboard bench for lfsr_encrypt_engine
module tb_lfsr_encrypt_engine;

  logic       clk = 1'b0;
  logic       start = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       halt;

  // bench-side load port into the model memory
  logic       tb_we = 1'b0;
  logic [7:0] tb_waddr = '0;
  logic [7:0] tb_wdata = '0;

  logic [7:0]  dm [0:255];
  logic [7:0]  msg [0:40];
  logic [7:0]  snap [0:63];
  logic [7:0]  exp_ct [0:63];
  logic [15:0] exp_q [$];

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  logic [7:0] cur_pre, cur_taps, cur_init;

  always #5 clk = ~clk;

  lfsr_encrypt_engine dut (
    .clk         (clk),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .halt        (halt)
  );

  always @(posedge clk) begin
    if (tb_we) dm[tb_waddr] <= tb_wdata;
    else if (mem_wr_en) dm[mem_addr] <= mem_wr_data;
    mem_rd_data <= dm[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write strobe pops the next expected {addr,data}.
  always @(negedge clk) begin
    if (!start && mem_wr_en) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'h0, mem_addr}, {24'h0, e[15:8]});
        chk("wr_data", {24'h0, mem_wr_data}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic dm_write(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic setup(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] init);
    logic [7:0] lf;
    int p;
    start = 1'b1;
    dm_write(8'd41, pre);
    dm_write(8'd42, taps);
    dm_write(8'd43, init);
    cur_pre = pre; cur_taps = taps; cur_init = init;
    exp_q.delete();
    lf = init;
    p = int'(pre);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] ptb;
      ptb = (i >= p && i < p + 41) ? msg[i - p] : 8'h20;
      exp_ct[i] = ptb ^ lf;
      exp_q.push_back({8'(64 + i), ptb ^ lf});
      lf = {lf[6:0], ^(lf & taps)};
    end
  endtask

  task automatic run_to_halt(input string tag);
    int edges;
    int halt_edge;
    halt_edge = -1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (edges < 300 && halt_edge < 0) begin
      @(posedge clk); #1;
      edges++;
      if (halt) halt_edge = edges;
    end
    chk({tag, "_halt_edge"}, halt_edge, 132);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    for (int i = 0; i < 64; i++) chk({tag, "_dm_out"}, {24'h0, dm[64 + i]}, {24'h0, exp_ct[i]});
  endtask

  initial begin
    string s;
    logic [7:0] init1;
    int halt_low;
    s = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 41; k++) msg[k] = s[k];

    #1;
    chk("rst_halt", {31'h0, halt}, 0);
    chk("rst_wr_en", {31'h0, mem_wr_en}, 0);
    chk("rst_wr_data", {24'h0, mem_wr_data}, 0);
    chk("rst_addr", {24'h0, mem_addr}, 41);

    for (int k = 0; k < 41; k++) dm_write(8'(k), msg[k]);
    for (int k = 44; k < 128; k++) dm_write(8'(k), 8'h00);
    #1;
    for (int k = 0; k < 64; k++) snap[k] = dm[k];

    // 1: nominal encryption
    init1 = 8'($urandom) | 8'h40;
    setup(8'd9, 8'hd4, init1);
    run_to_halt("t1");

    // 2: zero seed -> output is the padded plaintext itself
    setup(8'd9, 8'hb4, 8'h00);
    run_to_halt("t2");
    for (int i = 0; i < 9; i++) chk("t2_pad", {24'h0, dm[64 + i]}, 32'h20);
    for (int i = 0; i < 41; i++) chk("t2_msg", {24'h0, dm[73 + i]}, {24'h0, msg[i]});

    // 3: message truncated at byte 63
    setup(8'd30, 8'hd4, 8'h5a);
    run_to_halt("t3");

    // 4: message at byte 0, and message entirely past the output window
    setup(8'd0, 8'hd4, 8'h00);
    run_to_halt("t4a");
    for (int i = 0; i < 41; i++) chk("t4a_msg", {24'h0, dm[64 + i]}, {24'h0, msg[i]});
    setup(8'd200, 8'hd4, 8'h91);
    run_to_halt("t4b");

    // 5: abort while a write strobe is active, then rerun with a new seed
    setup(8'd9, 8'hd4, 8'h33);
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 51; e++) @(posedge clk);
    #1;
    chk("t5_wr_before", {31'h0, mem_wr_en}, 1);
    start = 1'b1;
    #1;
    chk("t5_wr_abort", {31'h0, mem_wr_en}, 0);
    chk("t5_halt_abort", {31'h0, halt}, 0);
    chk("t5_addr_abort", {24'h0, mem_addr}, 41);
    setup(8'd9, 8'hd4, 8'hc7);
    run_to_halt("t5");

    // 6: idle after halt
    wr_pulses = 0;
    halt_low = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!halt) halt_low++;
    end
    chk("t6_halt_low_cycles", halt_low, 0);
    chk("t6_wr_pulses", wr_pulses, 0);
    for (int k = 0; k < 64; k++) begin
      logic [7:0] ev;
      ev = (k < 41) ? msg[k] : (k == 41) ? cur_pre : (k == 42) ? cur_taps :
           (k == 43) ? cur_init : snap[k];
      chk("t6_dm_low", {24'h0, dm[k]}, {24'h0, ev});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
